encoder8_to_3: RTL and testbench
================================

# encoder8_to_3

Sequential 8-to-3 encoder, the inverse partner of the team's 3-to-8 decoder. It captures an 8-bit request or one-hot vector on a load strobe. It then emits the 3-bit index of every set bit, lowest index first, over a valid/ready handshake. Flags report empty, multi-hot and bit count, so upstream logic can check one-hot integrity before it re-decodes the index.

## Interface
Parameters:
- n, 3, index width
- m, 2**n, vector width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  active-low enable, same polarity as the decoder; 1 = block frozen
- load  input  1  capture strobe for dec_in
- dec_in  input  m  vector to encode
- enc  output  n  index of the current lowest pending bit; 0 when valid=0
- valid  output  1  enc holds a pending index
- ready  input  1  consumer accepts enc
- busy  output  1  a captured vector is not yet fully emitted
- done  output  1  one-cycle pulse when the captured vector is exhausted
- zero  output  1  captured vector was all-zero; registered at capture
- multi  output  1  captured vector had more than one bit set; registered at capture
- cnt  output  n+1  popcount of the captured vector (0..m); registered at capture

## Operation
- Reset (rst_n=0, async): state IDLE, pending register pend=0. Outputs enc=0, valid=0, busy=0, done=0, zero=0, multi=0, cnt=0.
- Internal state is pend[m-1:0] plus a 2-state FSM (IDLE, EMIT).
- IDLE:
  - If load=1 and en=0: pend<=dec_in; cnt<=popcount(dec_in); zero<=(dec_in==0); multi<=(cnt>1).
  - If dec_in!=0, go to EMIT.
  - If dec_in==0, stay in IDLE and pulse done next cycle.
  - load with en=1 is ignored.
- EMIT:
  - busy=1.
  - valid=!en.
  - enc = index of the lowest set bit of pend, decoded combinationally from the registered pend. enc stays stable while valid=1 and ready=0.
- Accept: valid=1 and ready=1 at a rising edge. On accept, the encoded bit is cleared in pend.
  - If pend becomes 0: go to IDLE and pulse done next cycle.
  - Otherwise stay in EMIT.
- en=1 during EMIT: valid=0, enc=0, no accept, pend and flags held. Emission resumes where it stopped when en returns to 0.
- load during EMIT is ignored; no queuing.
- zero, multi and cnt hold their values until the next accepted load or reset.

## Timing
- Capture latency: load at edge t gives valid=1 and busy=1 in the cycle after t.
- Throughput: one index per cycle while ready=1 and en=0.
- done:
  - For a non-empty vector, high for exactly the one cycle after the final accept. In that same cycle busy=0 and valid=0.
  - For an all-zero capture, high for the one cycle after the load edge, with zero=1 and busy=0.
- A load can be accepted in the same cycle that done is high, because the FSM is already in IDLE.
- Total emission time for a vector with k set bits and ready held high: k cycles.
- Reset mid-emission discards pend immediately. No done pulse is generated.
- dec_in=8'hFF: indices 0 through 7 in order, multi=1, cnt=8. cnt is wide enough to hold the full count without wrap.

## Structure
- Shared package encoder_pkg:
  - state enum {IDLE, EMIT}
  - localparams N=3, M=2**N
  - a popcount function
- One sub-module, lsb_encoder8_to_3: purely combinational. Inputs vec[m-1:0]. Outputs idx[n-1:0] (lowest set bit) and any (vec!=0).
- The FSM, pend register and flags live in the top level. The clear mask is the decoder-style one-hot of idx.

## Test plan
- Reset with dec_in=8'hA5 and load=1 held: all outputs 0 while rst_n=0. After release, load captures: cnt=4, multi=1, zero=0.
- One-hot 8'h10, ready=1: valid for one cycle with enc=3'd4, then done pulse, busy=0, multi=0, cnt=1.
- Vector 8'hA5, ready=1: enc sequence 0, 2, 5, 7 on consecutive cycles. done on the cycle after enc=7 is accepted.
- Vector 8'h0C, ready=0 for 3 cycles: enc=2 held stable with valid=1. Then ready=1 gives 2, 3, done.
- load with 8'h00: no valid. done=1 and zero=1 one cycle later; cnt=0.
- 8'hFF with en toggled to 1 after index 2: valid=0, enc=0 while en=1. After en=0, emission resumes at 3 and continues to 7. A load issued during EMIT is ignored. Asserting rst_n=0 mid-stream gives no done and all outputs 0.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types, sizes and helpers for the sequential 8-to-3 encoder.
package encoder_pkg;

    localparam int unsigned N = 3;
    localparam int unsigned M = 2 ** N;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Number of set bits in an M-bit vector; result is wide enough for M.
    function automatic logic [N:0] popcount(input logic [M-1:0] v);
        logic [N:0] c;
        c = '0;
        for (int i = 0; i < int'(M); i++) begin
            c = c + (N+1)'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/encoder8_to_3_if.sv
// Capture / emit bus of the sequential 8-to-3 encoder.
interface encoder8_to_3_if #(
    parameter int unsigned n = encoder_pkg::N
);
    localparam int unsigned m = 2 ** n;

    logic         en;
    logic         load;
    logic [m-1:0] dec_in;
    logic [n-1:0] enc;
    logic         valid;
    logic         ready;
    logic         busy;
    logic         done;
    logic         zero;
    logic         multi;
    logic [n:0]   cnt;

    modport master (
        output en, load, dec_in, ready,
        input  enc, valid, busy, done, zero, multi, cnt
    );

    modport slave (
        input  en, load, dec_in, ready,
        output enc, valid, busy, done, zero, multi, cnt
    );

endinterface

// File: rtl/lsb_encoder8_to_3.sv
// Combinational lowest-set-bit encoder with a non-empty flag.
module lsb_encoder8_to_3
    import encoder_pkg::*;
#(
    parameter int unsigned n = N,
    parameter int unsigned m = 2 ** n
) (
    input  logic [m-1:0] vec,
    output logic [n-1:0] idx,
    output logic         any
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = int'(m) - 1; i >= 0; i--) begin
            if (vec[i]) idx = n'(i);
        end
        any = |vec;
    end

endmodule

// File: rtl/encoder8_to_3.sv
// Sequential 8-to-3 encoder: captures a vector, then emits each set index
// lowest first over valid/ready, with empty / multi-hot / count flags.
module encoder8_to_3
    import encoder_pkg::*;
#(
    parameter int unsigned n = N,
    parameter int unsigned m = 2 ** n
) (
    input  logic            clk,
    input  logic            rst_n,
    encoder8_to_3_if.slave  bus
);

    state_t       state_q;
    state_t       state_d;
    logic [m-1:0] pend_q;
    logic [m-1:0] clr_mask;
    logic [m-1:0] pend_left;
    logic [n-1:0] idx;
    logic         any;
    logic         capture;
    logic         accept;
    logic         valid_c;
    logic         busy_c;
    logic [n-1:0] enc_c;
    logic         done_q;
    logic         zero_q;
    logic         multi_q;
    logic [n:0]   cnt_q;
    logic [n:0]   pop_c;

    lsb_encoder8_to_3 #(.n(n), .m(m)) u_lsb (
        .vec (pend_q),
        .idx (idx),
        .any (any)
    );

    assign capture   = (state_q == IDLE) && bus.load && !bus.en;
    assign accept    = valid_c && bus.ready;
    assign clr_mask  = m'(1) << idx;
    assign pend_left = pend_q & ~clr_mask;
    assign pop_c     = (n+1)'(popcount(M'(bus.dec_in)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; an all-zero capture never leaves IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (capture && (bus.dec_in != '0)) state_d = EMIT;
            EMIT: if (accept && (pend_left == '0))   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; enc reads as zero whenever nothing is offered.
    always_comb begin
        valid_c = 1'b0;
        busy_c  = 1'b0;
        enc_c   = '0;
        if (state_q == EMIT) begin
            busy_c  = 1'b1;
            valid_c = !bus.en && any;
            if (valid_c) enc_c = idx;
        end
    end

    // Pending vector, capture-time flags and the exhaustion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            multi_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (capture) begin
                pend_q  <= bus.dec_in;
                cnt_q   <= pop_c;
                zero_q  <= (bus.dec_in == '0);
                multi_q <= (pop_c > (n+1)'(1));
            end else if (accept) begin
                pend_q <= pend_left;
            end
            done_q <= (capture && (bus.dec_in == '0)) ||
                      (accept && (pend_left == '0));
        end
    end

    assign bus.enc   = enc_c;
    assign bus.valid = valid_c;
    assign bus.busy  = busy_c;
    assign bus.done  = done_q;
    assign bus.zero  = zero_q;
    assign bus.multi = multi_q;
    assign bus.cnt   = cnt_q;

endmodule

// File: tb/tb_encoder8_to_3.sv
// Self-checking bench for encoder8_to_3 against a queue-based reference model.
module tb_encoder8_to_3;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    encoder8_to_3_if bus ();

    encoder8_to_3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the pending indices as a list, plus captured flags.
    int         q[$];
    logic       m_done;
    logic       m_zero;
    logic       m_multi;
    logic [3:0] m_cnt;

    task automatic model_reset();
        q.delete();
        m_done  = 1'b0;
        m_zero  = 1'b0;
        m_multi = 1'b0;
        m_cnt   = 4'd0;
    endtask

    function automatic logic [11:0] expect_out();
        logic       b;
        logic       v;
        logic [2:0] e;
        b = (q.size() != 0);
        v = b && !bus.en;
        e = v ? 3'(q[0]) : 3'd0;
        return {v, e, b, m_done, m_zero, m_multi, m_cnt};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.valid, bus.enc, bus.busy, bus.done, bus.zero, bus.multi, bus.cnt};
    endfunction

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_edge();
        logic b;
        logic acc;
        b      = (q.size() != 0);
        acc    = b && !bus.en && bus.ready;
        m_done = 1'b0;
        if (acc) begin
            void'(q.pop_front());
            if (q.size() == 0) m_done = 1'b1;
        end else if (!b && bus.load && !bus.en) begin
            q.delete();
            for (int i = 0; i < 8; i++) if (bus.dec_in[i]) q.push_back(i);
            m_cnt   = 4'(q.size());
            m_zero  = (q.size() == 0);
            m_multi = (q.size() > 1);
            m_done  = m_zero;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic l, input logic [7:0] d, input logic e, input logic r);
        bus.load   = l;
        bus.dec_in = d;
        bus.en     = e;
        bus.ready  = r;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        apply(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs() !== 12'h000) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c, obs(), 12'h000);
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        apply(1'b1, 8'hA5, 1'b0, 1'b0);
        tick();
        apply(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({bus.cnt, bus.multi, bus.zero, bus.valid, bus.busy} !== {4'd4, 1'b1, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset_capture got cnt=%0d multi=%b zero=%b valid=%b busy=%b exp cnt=4 multi=1 zero=0 valid=1 busy=1",
                     bus.cnt, bus.multi, bus.zero, bus.valid, bus.busy);
        end
        for (int c = 0; c < 6; c++) begin
            apply(1'b0, 8'h00, 1'b0, 1'b1);
            checks++;
            if (obs() !== expect_out()) begin
                failures++;
                $display("FAIL reset_drain cyc=%0d got=%h exp=%h", c, obs(), expect_out());
            end
            tick();
        end
    endtask

    task automatic test_onehot();
        apply(1'b1, 8'h10, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 8'h00, 1'b0, 1'b1);
            checks++;
            if (obs() !== expect_out()) begin
                failures++;
                $display("FAIL onehot cyc=%0d got=%h exp=%h", c, obs(), expect_out());
            end
            if (c == 0) begin
                checks++;
                if ({bus.valid, bus.enc, bus.multi, bus.cnt} !== {1'b1, 3'd4, 1'b0, 4'd1}) begin
                    failures++;
                    $display("FAIL onehot_index got valid=%b enc=%0d multi=%b cnt=%0d exp 1 4 0 1",
                             bus.valid, bus.enc, bus.multi, bus.cnt);
                end
            end
            if (c == 1) begin
                checks++;
                if ({bus.done, bus.busy, bus.valid} !== 3'b100) begin
                    failures++;
                    $display("FAIL onehot_done got done=%b busy=%b valid=%b exp 1 0 0", bus.done, bus.busy, bus.valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_sequence();
        logic [2:0] seq [4];
        seq = '{3'd0, 3'd2, 3'd5, 3'd7};
        apply(1'b1, 8'hA5, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < 5; c++) begin
            apply(1'b0, 8'h00, 1'b0, 1'b1);
            checks++;
            if (obs() !== expect_out()) begin
                failures++;
                $display("FAIL seq_a5 cyc=%0d got=%h exp=%h", c, obs(), expect_out());
            end
            if (c < 4) begin
                checks++;
                if (bus.enc !== seq[c]) begin
                    failures++;
                    $display("FAIL seq_a5_enc cyc=%0d got=%0d exp=%0d", c, bus.enc, seq[c]);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        apply(1'b1, 8'h0C, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 6; c++) begin
            apply(1'b0, 8'h00, 1'b0, (c >= 3));
            checks++;
            if (obs() !== expect_out()) begin
                failures++;
                $display("FAIL stall cyc=%0d got=%h exp=%h", c, obs(), expect_out());
            end
            if (c < 3) begin
                checks++;
                if ({bus.valid, bus.enc} !== {1'b1, 3'd2}) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got valid=%b enc=%0d exp 1 2", c, bus.valid, bus.enc);
                end
            end
            tick();
        end
    endtask

    task automatic test_zero_and_back_to_back();
        apply(1'b1, 8'h00, 1'b0, 1'b1);
        checks++;
        if (obs() !== expect_out()) begin
            failures++;
            $display("FAIL zero_load got=%h exp=%h", obs(), expect_out());
        end
        tick();
        // done cycle of the empty capture: a new load is taken right away
        apply(1'b1, 8'h81, 1'b0, 1'b1);
        checks++;
        if ({bus.done, bus.zero, bus.busy, bus.valid, bus.cnt} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL zero_done got done=%b zero=%b busy=%b valid=%b cnt=%0d exp 1 1 0 0 0",
                     bus.done, bus.zero, bus.busy, bus.valid, bus.cnt);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 8'h00, 1'b0, 1'b1);
            checks++;
            if (obs() !== expect_out()) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs(), expect_out());
            end
            tick();
        end
    endtask

    task automatic test_en_freeze_and_abort();
        apply(1'b1, 8'hFF, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < 10; c++) begin
            // accept 0..2, freeze 3 cycles, then run with a stray load
            if (c < 3)      apply(1'b0, 8'h00, 1'b0, 1'b1);
            else if (c < 6) apply(1'b1, 8'h01, 1'b1, 1'b1);
            else            apply(1'b1, 8'h01, 1'b0, 1'b1);
            checks++;
            if (obs() !== expect_out()) begin
                failures++;
                $display("FAIL en_freeze cyc=%0d got=%h exp=%h", c, obs(), expect_out());
            end
            if (c == 6) begin
                checks++;
                if ({bus.enc, bus.cnt, bus.multi} !== {3'd3, 4'd8, 1'b1}) begin
                    failures++;
                    $display("FAIL en_resume got enc=%0d cnt=%0d multi=%b exp 3 8 1", bus.enc, bus.cnt, bus.multi);
                end
            end
            tick();
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs() !== 12'h000) begin
            failures++;
            $display("FAIL abort_reset got=%h exp=%h", obs(), 12'h000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=%b exp=0", bus.done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            apply(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) != 0));
            checks++;
            if (obs() !== expect_out()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs(), expect_out());
            end
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_onehot();
        test_sequence();
        test_stall();
        test_zero_and_back_to_back();
        test_en_freeze_and_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
